wb_burst_master: RTL

Synthesizable Wishbone initiator that drives the SDRAM controller's Wishbone slave port inside the emulation image. It replaces the tied-off `wb_*` stimulus with real traffic. It accepts single- or multi-beat read/write commands on a valid/ready command port, streams write data in and read data out, and reports completion or timeout per command. It sits on the `sys_clk` domain, between the transaction layer and `wishbone_interface`.

---
 rtl/wb_burst_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// ============================================================================
// Module   : wb_burst_master
// Brief    : Wishbone burst initiator: valid/ready command port, streamed
//            write/read data, per-command done with timeout error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_burst_master #(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int LENW    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic [DW-1:0]     wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DW-1:0]     rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              done_err,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wdat = 2'd1;
    localparam logic [1:0] c_st_beat = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // Counter only needs to reach TIMEOUT-1: the abort fires on that cycle.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0]   c_tmo_last  = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0]   c_addr_step = AW'(DW / 8);

    logic [1:0]      r_state;
    logic            r_we;
    logic            r_single;
    logic            r_cyc;
    logic            r_err;
    logic            r_rvalid;
    logic [AW-1:0]   r_addr;
    logic [LENW-1:0] r_cnt;
    logic [TW-1:0]   r_tmo;
    logic [DW-1:0]   r_dat_o;
    logic [DW-1:0]   r_rdata;

    logic            w_beat;
    logic            w_done;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= c_st_idle;
            r_we     <= 1'b0;
            r_single <= 1'b0;
            r_cyc    <= 1'b0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_dat_o  <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_we     <= cmd_we;
                        r_addr   <= cmd_addr;
                        r_cnt    <= cmd_len;
                        r_single <= (cmd_len == '0);
                        r_tmo    <= '0;
                        r_err    <= 1'b0;
                        if (cmd_we) begin
                            r_state <= c_st_wdat;
                        end else begin
                            r_state <= c_st_beat;
                            r_cyc   <= 1'b1;
                        end
                    end
                end
                c_st_wdat: begin
                    if (wdata_valid) begin
                        r_dat_o <= wdata;
                        r_state <= c_st_beat;
                        r_cyc   <= 1'b1;
                    end
                end
                c_st_beat: begin
                    if (wb_ack_i) begin
                        r_tmo <= '0;
                        if (!r_we) begin
                            r_rdata  <= wb_dat_i;
                            r_rvalid <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            r_cyc   <= 1'b0;
                            r_state <= c_st_done;
                        end else begin
                            r_addr <= r_addr + c_addr_step;
                            r_cnt  <= r_cnt - 1'b1;
                            // Writes fetch the next beat; cyc stays up across the gap.
                            if (r_we) begin
                                r_state <= c_st_wdat;
                            end
                        end
                    end else if (r_tmo == c_tmo_last) begin
                        r_cyc   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_st_done: begin
                    r_err   <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign w_beat = (r_state == c_st_beat);
    assign w_done = (r_state == c_st_done);

    assign cmd_ready   = (r_state == c_st_idle) && !wb_rst_i;
    assign wdata_ready = (r_state == c_st_wdat);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rvalid;
    assign done        = w_done;
    assign done_err    = w_done && r_err;

    assign wb_addr_o = r_addr;
    assign wb_dat_o  = r_dat_o;
    assign wb_sel_o  = {(DW/8){w_beat}};
    assign wb_we_o   = w_beat && r_we;
    assign wb_stb_o  = w_beat;
    assign wb_cyc_o  = r_cyc;
    assign wb_cti_o  = (!w_beat || r_single) ? 3'b000 :
                       (r_cnt == '0)         ? 3'b111 : 3'b010;

endmodule

`default_nettype wire
